// File: rtl/pcm_mm_scheduler_if.sv
// Handshake and PCM pin bundle between the per-port requester, the scheduler and the array.
// The slave modport is the scheduler's view; master is the requester/array side.
interface pcm_mm_scheduler_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              schedule;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              resolved;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              pcm_cs;
  logic              pcm_we;
  logic [ADDR_W-1:0] pcm_addr;
  logic [DATA_W-1:0] pcm_wdata;
  logic [DATA_W-1:0] pcm_rdata;

  modport slave (
    input  schedule, req_addr, req_write, req_wdata, pcm_rdata,
    output resolved, resp_data, busy, pcm_cs, pcm_we, pcm_addr, pcm_wdata
  );

  modport master (
    output schedule, req_addr, req_write, req_wdata, pcm_rdata,
    input  resolved, resp_data, busy, pcm_cs, pcm_we, pcm_addr, pcm_wdata
  );
endinterface

// File: rtl/pcm_mm_scheduler.sv
// Responder for the PCM main-memory conflict handshake: one fixed-latency array access per request.
// Defining PCM_MM_SCHED_RBUF_EN adds a one-entry write-through read buffer.
module pcm_mm_scheduler #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 12
) (
  input logic               clk,
  input logic               reset,
  pcm_mm_scheduler_if.slave bus
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_respData;
  logic              r_resolved;
  logic              r_busy;
  logic              r_cs;

`ifdef PCM_MM_SCHED_RBUF_EN
  logic              r_bufValid;
  logic [ADDR_W-1:0] r_bufAddr;
  logic [DATA_W-1:0] r_bufData;
  logic              w_bufHit;

  assign w_bufHit = r_bufValid && !bus.req_write && (r_bufAddr == bus.req_addr);
`endif

  // The captured request registers double as the array pins, so they hold between accesses.
  assign bus.resolved  = r_resolved;
  assign bus.resp_data = r_respData;
  assign bus.busy      = r_busy;
  assign bus.pcm_cs    = r_cs;
  assign bus.pcm_we    = r_write;
  assign bus.pcm_addr  = r_addr;
  assign bus.pcm_wdata = r_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_respData <= '0;
      r_resolved <= 1'b0;
      r_busy     <= 1'b0;
      r_cs       <= 1'b0;
`ifdef PCM_MM_SCHED_RBUF_EN
      r_bufValid <= 1'b0;
      r_bufAddr  <= '0;
      r_bufData  <= '0;
`endif
    end else begin
      r_cs       <= 1'b0;
      r_resolved <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.schedule) begin
            r_busy <= 1'b1;
`ifdef PCM_MM_SCHED_RBUF_EN
            if (w_bufHit) begin
              r_respData <= r_bufData;
              r_resolved <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_addr  <= bus.req_addr;
              r_write <= bus.req_write;
              r_wdata <= bus.req_wdata;
              r_cs    <= 1'b1;
              r_state <= S_ISSUE;
            end
`else
            r_addr  <= bus.req_addr;
            r_write <= bus.req_write;
            r_wdata <= bus.req_wdata;
            r_cs    <= 1'b1;
            r_state <= S_ISSUE;
`endif
          end
        end
        S_ISSUE: begin
          r_cnt   <= r_write ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid in the last WAIT cycle, exactly RD_LAT cycles after the strobe.
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt      <= '0;
            r_resolved <= 1'b1;
            r_state    <= S_RESP;
            r_respData <= r_write ? r_wdata : bus.pcm_rdata;
`ifdef PCM_MM_SCHED_RBUF_EN
            if (!r_write) begin
              r_bufValid <= 1'b1;
              r_bufAddr  <= r_addr;
              r_bufData  <= bus.pcm_rdata;
            end else if (r_bufValid && (r_bufAddr == r_addr)) begin
              r_bufData <= r_wdata;
            end
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    assert (RD_LAT >= 1 && WR_LAT >= 1)
      else $error("pcm_mm_scheduler: RD_LAT and WR_LAT must both be at least 1");
  end

endmodule

// File: tb/tb_pcm_mm_scheduler.sv
// Directed self-checking bench for pcm_mm_scheduler with a small array model.
// Buffer scenarios are compiled in only when PCM_MM_SCHED_RBUF_EN is defined.
module tb_pcm_mm_scheduler;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 12;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] arrayData;
  int                pend;

  int                nCs, csAt, lastCsAt, nRes, resAt, nLate;
  logic [ADDR_W-1:0] csAddr;
  logic              csWe;
  logic [DATA_W-1:0] csWdata;
  logic [DATA_W-1:0] respAtRes;
  logic [63:0]       busyTrace;

  pcm_mm_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pcm_mm_scheduler #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Array model: read data appears only in the cycle exactly RD_LAT after the strobe cycle.
  initial begin
    pend          = 0;
    bus.pcm_rdata = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      bus.pcm_rdata = 16'hDEAD;
      if (pend > 0) begin
        pend--;
        if (pend == 0) bus.pcm_rdata = arrayData;
      end
      if (bus.pcm_cs && !bus.pcm_we) pend = RD_LAT;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    bus.schedule = 1'b0;
    while (bus.busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) checkOutput("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Issues one request and records strobe/response timing relative to the accepting edge E0.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic wr,
                               input logic [DATA_W-1:0] wdata, input int cycles, input bit hold);
    waitIdle();
    @(negedge clk);
    bus.schedule  = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    nCs = 0; csAt = 0; lastCsAt = 0; nRes = 0; resAt = 0;
    csAddr = '0; csWe = 1'b0; csWdata = '0; respAtRes = '0; busyTrace = '0;
    @(posedge clk);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      busyTrace[c] = bus.busy;
      if (bus.pcm_cs) begin
        nCs++;
        lastCsAt = c;
        if (nCs == 1) begin
          csAt    = c;
          csAddr  = bus.pcm_addr;
          csWe    = bus.pcm_we;
          csWdata = bus.pcm_wdata;
        end
      end
      if (bus.resolved) begin
        nRes++;
        if (nRes == 1) begin
          resAt     = c;
          respAtRes = bus.resp_data;
        end
        if (!hold) bus.schedule = 1'b0;
      end
      if (c == 3) begin
        bus.req_addr  = addr ^ {ADDR_W{1'b1}};
        bus.req_wdata = wdata ^ {DATA_W{1'b1}};
      end
    end
    bus.schedule = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.schedule  = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    arrayData     = 16'hBEEF;

    repeat (3) @(negedge clk);
    checkOutput("rst_resolved", 32'(bus.resolved), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_cs", 32'(bus.pcm_cs), 32'd0);
    checkOutput("rst_we", 32'(bus.pcm_we), 32'd0);
    checkOutput("rst_addr", 32'(bus.pcm_addr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.pcm_wdata), 32'd0);
    checkOutput("rst_resp", 32'(bus.resp_data), 32'd0);
    reset = 1'b0;

    // Read with the request address disturbed during WAIT.
    applyStimulus(20'h12345, 1'b0, 16'h0000, RD_LAT + 6, 1'b0);
    checkOutput("rd_cs_count", nCs, 1);
    checkOutput("rd_cs_cycle", csAt, 1);
    checkOutput("rd_cs_we", 32'(csWe), 32'd0);
    checkOutput("rd_cs_addr", 32'(csAddr), 32'h12345);
    checkOutput("rd_res_count", nRes, 1);
    checkOutput("rd_res_cycle", resAt, 6);
    checkOutput("rd_resp", 32'(respAtRes), 32'hBEEF);
    checkOutput("rd_busy_c1", 32'(busyTrace[1]), 32'd1);
    checkOutput("rd_busy_gap", 32'(busyTrace[7]), 32'd1);
    checkOutput("rd_busy_idle", 32'(busyTrace[8]), 32'd0);
    checkOutput("rd_addr_hold", 32'(bus.pcm_addr), 32'h12345);
    checkOutput("rd_resp_hold", 32'(bus.resp_data), 32'hBEEF);

    // Write: response echoes the captured data, not the disturbed input.
    applyStimulus(20'h00010, 1'b1, 16'hA5A5, WR_LAT + 6, 1'b0);
    checkOutput("wr_cs_count", nCs, 1);
    checkOutput("wr_cs_cycle", csAt, 1);
    checkOutput("wr_cs_we", 32'(csWe), 32'd1);
    checkOutput("wr_cs_addr", 32'(csAddr), 32'h00010);
    checkOutput("wr_cs_wdata", 32'(csWdata), 32'hA5A5);
    checkOutput("wr_res_cycle", resAt, 14);
    checkOutput("wr_res_count", nRes, 1);
    checkOutput("wr_resp", 32'(respAtRes), 32'hA5A5);
    checkOutput("wr_busy_idle", 32'(busyTrace[16]), 32'd0);
    checkOutput("wr_wdata_hold", 32'(bus.pcm_wdata), 32'hA5A5);

    // Schedule left high: re-acceptance only from IDLE, one cycle after GAP.
    arrayData = 16'h3C3C;
    applyStimulus(20'h00040, 1'b0, 16'h0000, RD_LAT + 8, 1'b1);
    checkOutput("hold_cs_count", nCs, 2);
    checkOutput("hold_cs_first", csAt, 1);
    checkOutput("hold_cs_second", lastCsAt, RD_LAT + 5);
    checkOutput("hold_res_cycle", resAt, RD_LAT + 2);
    checkOutput("hold_res_count", nRes, 1);
    checkOutput("hold_resp", 32'(respAtRes), 32'h3C3C);
    checkOutput("hold_busy_gap", 32'(busyTrace[RD_LAT + 3]), 32'd1);
    checkOutput("hold_busy_idle", 32'(busyTrace[RD_LAT + 4]), 32'd0);

    // Asynchronous reset in cycle 3 of a write.
    waitIdle();
    @(negedge clk);
    bus.schedule  = 1'b1;
    bus.req_addr  = 20'h00077;
    bus.req_write = 1'b1;
    bus.req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_cs_c1", 32'(bus.pcm_cs), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_cs", 32'(bus.pcm_cs), 32'd0);
    checkOutput("mid_resolved", 32'(bus.resolved), 32'd0);
    checkOutput("mid_we", 32'(bus.pcm_we), 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    bus.schedule = 1'b0;
    nLate = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.resolved) nLate++;
    end
    checkOutput("mid_no_resolved", nLate, 0);

    arrayData = 16'h5A5A;
    applyStimulus(20'h00123, 1'b0, 16'h0000, RD_LAT + 6, 1'b0);
    checkOutput("post_cs_addr", 32'(csAddr), 32'h00123);
    checkOutput("post_res_cycle", resAt, 6);
    checkOutput("post_resp", 32'(respAtRes), 32'h5A5A);

`ifdef PCM_MM_SCHED_RBUF_EN
    arrayData = 16'h1111;
    applyStimulus(20'h00020, 1'b0, 16'h0000, RD_LAT + 6, 1'b0);
    checkOutput("buf_fill_cs", nCs, 1);
    checkOutput("buf_fill_resp", 32'(respAtRes), 32'h1111);

    arrayData = 16'h9999;
    applyStimulus(20'h00020, 1'b0, 16'h0000, 6, 1'b0);
    checkOutput("buf_hit_cs", nCs, 0);
    checkOutput("buf_hit_res_cycle", resAt, 1);
    checkOutput("buf_hit_resp", 32'(respAtRes), 32'h1111);
    checkOutput("buf_hit_busy_c1", 32'(busyTrace[1]), 32'd1);
    checkOutput("buf_hit_busy_idle", 32'(busyTrace[3]), 32'd0);

    applyStimulus(20'h00020, 1'b1, 16'h2222, WR_LAT + 6, 1'b0);
    checkOutput("buf_wr_res_cycle", resAt, 14);
    applyStimulus(20'h00021, 1'b1, 16'h7777, WR_LAT + 6, 1'b0);
    checkOutput("buf_wr_other_cs", nCs, 1);

    applyStimulus(20'h00020, 1'b0, 16'h0000, 6, 1'b0);
    checkOutput("buf_wt_cs", nCs, 0);
    checkOutput("buf_wt_res_cycle", resAt, 1);
    checkOutput("buf_wt_resp", 32'(respAtRes), 32'h2222);
`endif

    waitIdle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
